data_gen_ctrl: RTL and testbench

//  Controllable test-pattern source for the dynamic 595 seven-segment path.

---
 rtl/data_gen_ctrl.sv | 130 +++++++++++++
 tb/tb_data_gen_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_gen_ctrl.sv
// Test-pattern source for the seven-segment path: a signed up/down counter stepped by a prescaled tick.
// Supports run/hold/idle control, preload, and wrap or saturate at the range limits.
module data_gen_ctrl #(
   parameter int unsigned       CNT_W     = 23,
   parameter logic [CNT_W-1:0]  CNT_TICK  = 23'd4_999_999,
   parameter int unsigned       DATA_W    = 20,
   parameter logic [DATA_W-1:0] DATA_MAX  = 20'd999_999,
   parameter logic [DATA_W-1:0] STEP      = 20'd1,
   parameter bit                SIGNED_EN = 1'b0,
   parameter bit                WRAP      = 1'b1,
   parameter int unsigned       DIGITS    = 6,
   parameter logic [DIGITS-1:0] POINT_POS = 6'b000000
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              start,
   input  logic              pause,
   input  logic              stop,
   input  logic              dir,
   input  logic              load,
   input  logic [DATA_W-1:0] load_val,
   input  logic              load_neg,
   output logic [DATA_W-1:0] data,
   output logic [DIGITS-1:0] point,
   output logic              sign,
   output logic              seg_en,
   output logic              tick,
   output logic              at_limit
);

   localparam int unsigned VW = DATA_W + 2;
   localparam logic signed [VW-1:0] MAX_S   = $signed(VW'(DATA_MAX));
   localparam logic signed [VW-1:0] MIN_S   = SIGNED_EN ? -MAX_S : '0;
   localparam logic signed [VW-1:0] STEP_S  = $signed(VW'(STEP));
   localparam logic [CNT_W-1:0]     CNT_PRE = CNT_TICK - CNT_W'(1);

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t              state, state_next;
   logic [CNT_W-1:0]    cnt, cnt_next;
   logic                tick_next;
   logic [DATA_W-1:0]   data_next, step_mag, load_mag;
   logic                sign_next, step_neg, load_sgn;
   logic signed [VW-1:0] cur_s, sum_s, res_s, abs_s;

   // One step of the signed value with limit handling; wide enough that the sum never overflows.
   always_comb begin
      cur_s = $signed(VW'(data));
      if (sign) cur_s = -cur_s;
      sum_s = dir ? (cur_s - STEP_S) : (cur_s + STEP_S);
      if (sum_s > MAX_S)      res_s = WRAP ? MIN_S : MAX_S;
      else if (sum_s < MIN_S) res_s = WRAP ? MAX_S : MIN_S;
      else                    res_s = sum_s;
      step_neg = res_s[VW-1];
      abs_s    = step_neg ? -res_s : res_s;
      step_mag = DATA_W'(abs_s);
   end

   assign load_mag = (load_val > DATA_MAX) ? DATA_MAX : load_val;
   assign load_sgn = SIGNED_EN && load_neg && (load_mag != '0);

   // Next state and datapath: stop beats load, load beats start/pause, those beat the tick update.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      tick_next  = 1'b0;
      data_next  = data;
      sign_next  = sign;
      if (stop) begin
         state_next = IDLE;
         cnt_next   = '0;
         data_next  = '0;
         sign_next  = 1'b0;
      end else if (load) begin
         cnt_next  = '0;
         data_next = load_mag;
         sign_next = load_sgn;
      end else begin
         unique case (state)
            IDLE: begin
               cnt_next = '0;
               if (start) state_next = RUN;
            end
            RUN: begin
               if (pause) begin
                  state_next = HOLD;
               end else begin
                  cnt_next  = (cnt == CNT_TICK) ? '0 : cnt + CNT_W'(1);
                  tick_next = (cnt == CNT_PRE);
                  if (tick) begin
                     data_next = step_mag;
                     sign_next = step_neg;
                  end
               end
            end
            HOLD: begin
               if (pause) state_next = RUN;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= IDLE;
      else            state <= state_next;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt    <= '0;
         tick   <= 1'b0;
         data   <= '0;
         sign   <= 1'b0;
         seg_en <= 1'b0;
      end else begin
         cnt    <= cnt_next;
         tick   <= tick_next;
         data   <= data_next;
         sign   <= sign_next;
         seg_en <= 1'b1;
      end
   end

   // IDLE masks the flag so an unsigned counter parked at zero after reset reports no limit.
   assign at_limit = (state != IDLE) &&
                     ((data == DATA_MAX) || (!SIGNED_EN && (data == '0)));
   assign point    = POINT_POS;

endmodule

// File: tb/tb_data_gen_ctrl.sv
// Bench for data_gen_ctrl: four parameter variants share one stimulus stream and are
// checked each cycle against an integer model, plus directed literal checks.
module tb_data_gen_ctrl;

   localparam int NI   = 4;
   localparam int T    = 4;
   localparam int DMAX = 9;
   localparam int DW   = 4;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_HOLD = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic start, pause, stop, dir, load, load_neg;
   logic [DW-1:0] load_val;
   logic [DW-1:0] data_o  [NI];
   logic [5:0]    point_o [NI];
   logic          sign_o  [NI];
   logic          seg_o   [NI];
   logic          tick_o  [NI];
   logic          lim_o   [NI];

   // variant table: 0 unsigned wrap, 1 signed wrap, 2 unsigned saturate, 3 signed wrap step 4
   int smin [NI] = '{0, -9, 0, -9};
   int stp  [NI] = '{1, 1, 1, 4};
   bit wrp  [NI] = '{1'b1, 1'b1, 1'b0, 1'b1};
   bit sgn  [NI] = '{1'b0, 1'b1, 1'b0, 1'b1};

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      data_gen_ctrl #(
         .CNT_W(3), .CNT_TICK(3'd4), .DATA_W(DW), .DATA_MAX(4'd9),
         .STEP((g == 3) ? 4'd4 : 4'd1),
         .SIGNED_EN((g == 1) || (g == 3)),
         .WRAP(g != 2), .DIGITS(6), .POINT_POS(6'b010010)
      ) u_dut (
         .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .pause(pause), .stop(stop),
         .dir(dir), .load(load), .load_val(load_val), .load_neg(load_neg),
         .data(data_o[g]), .point(point_o[g]), .sign(sign_o[g]), .seg_en(seg_o[g]),
         .tick(tick_o[g]), .at_limit(lim_o[g])
      );
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_mode, m_ph;
   bit m_tick, m_seg;
   int m_val [NI];

   function automatic int next_val(int v, int i, bit d);
      int r;
      r = d ? v - stp[i] : v + stp[i];
      if (r > DMAX)         r = wrp[i] ? smin[i] : DMAX;
      else if (r < smin[i]) r = wrp[i] ? DMAX : smin[i];
      return r;
   endfunction

   function automatic int load_value(int i, int lv, bit neg);
      int m;
      m = (lv > DMAX) ? DMAX : lv;
      return (sgn[i] && neg) ? -m : m;
   endfunction

   always @(posedge clk or negedge rst_n) begin : p_model
      bit was_tick;
      if (!rst_n) begin
         m_mode = M_IDLE; m_ph = 0; m_tick = 1'b0; m_seg = 1'b0;
         for (int i = 0; i < NI; i++) m_val[i] = 0;
      end else begin
         was_tick = m_tick;
         m_tick   = 1'b0;
         m_seg    = 1'b1;
         if (stop) begin
            m_mode = M_IDLE; m_ph = 0;
            for (int i = 0; i < NI; i++) m_val[i] = 0;
         end else if (load) begin
            m_ph = 0;
            for (int i = 0; i < NI; i++) m_val[i] = load_value(i, int'(load_val), load_neg);
         end else if (m_mode == M_IDLE) begin
            if (start) m_mode = M_RUN;
         end else if (pause) begin
            m_mode = (m_mode == M_RUN) ? M_HOLD : M_RUN;
         end else if (m_mode == M_RUN) begin
            m_ph   = (m_ph + 1) % (T + 1);
            m_tick = (m_ph == T);
            if (was_tick)
               for (int i = 0; i < NI; i++) m_val[i] = next_val(m_val[i], i, dir);
         end
      end
   end

   always @(posedge clk) begin : p_cmp
      int e;
      #1;
      for (int i = 0; i < NI; i++) begin
         e = m_val[i];
         chk($sformatf("data%0d", i), int'(data_o[i]), (e < 0) ? -e : e);
         chk($sformatf("sign%0d", i), int'(sign_o[i]), int'(e < 0));
         chk($sformatf("at_limit%0d", i), int'(lim_o[i]),
             int'((m_mode != M_IDLE) && ((e == DMAX) || (e == smin[i]))));
         chk($sformatf("tick%0d", i), int'(tick_o[i]), int'(m_tick));
         chk($sformatf("seg_en%0d", i), int'(seg_o[i]), int'(m_seg));
         chk($sformatf("point%0d", i), int'(point_o[i]), 18);
      end
   end

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while ((tick_o[0] !== 1'b1) && (n < 40));
      if (tick_o[0] !== 1'b1) begin
         total++; bad++;
         $display("FAIL tick_timeout: no tick within %0d clocks at %0t", n, $time);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin : p_stim
      int n, cnt;
      rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0; dir = 1'b0;
      load = 1'b0; load_neg = 1'b0; load_val = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", int'(data_o[0]), 0);
      chk("rst_seg_en", int'(seg_o[0]), 0);
      chk("rst_tick", int'(tick_o[0]), 0);
      chk("rst_at_limit", int'(lim_o[0]), 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("seg_en_release", int'(seg_o[0]), 1);

      // count up through ten updates
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_tick(n); chk("first_tick_latency", n, 4);
      wait_tick(n); chk("tick_period", n, 5);
      repeat (8) wait_tick(n);
      @(posedge clk); #1;
      chk("wrap_u0_data", int'(data_o[0]), 0);
      chk("wrap_u1_data", int'(data_o[1]), 9);
      chk("wrap_u1_sign", int'(sign_o[1]), 1);
      chk("wrap_u1_lim", int'(lim_o[1]), 1);
      chk("sat_u2_data", int'(data_o[2]), 9);
      chk("sat_u2_lim", int'(lim_o[2]), 1);
      chk("step4_u3_data", int'(data_o[3]), 1);
      chk("step4_u3_sign", int'(sign_o[3]), 1);

      // pause with prescaler at 2, hold, resume
      repeat (3) @(negedge clk);
      pause = 1'b1;
      @(negedge clk) pause = 1'b0;
      cnt = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (tick_o[0]) cnt++;
      end
      chk("hold_ticks", cnt, 0);
      @(negedge clk) pause = 1'b1;
      @(negedge clk) pause = 1'b0;
      wait_tick(n); chk("resume_tick", n, 2);

      // load on a tick cycle overrides the update and restarts the prescaler
      @(negedge clk) begin load = 1'b1; load_val = 4'd7; load_neg = 1'b0; end
      @(posedge clk); #1;
      chk("load_u0_data", int'(data_o[0]), 7);
      chk("load_u3_data", int'(data_o[3]), 7);
      @(negedge clk) load = 1'b0;
      wait_tick(n); chk("tick_after_load", n, 4);

      // stop and load together on a tick cycle
      @(negedge clk) begin load = 1'b1; stop = 1'b1; load_val = 4'd7; end
      @(posedge clk); #1;
      chk("stop_u0_data", int'(data_o[0]), 0);
      chk("stop_u3_data", int'(data_o[3]), 0);
      @(negedge clk) begin load = 1'b0; stop = 1'b0; end
      cnt = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (tick_o[0]) cnt++;
      end
      chk("idle_ticks", cnt, 0);

      // preload clamp
      @(negedge clk) begin load = 1'b1; load_val = 4'd15; load_neg = 1'b1; end
      @(posedge clk); #1;
      chk("clamp_u0_data", int'(data_o[0]), 9);
      chk("clamp_u0_sign", int'(sign_o[0]), 0);
      chk("clamp_u1_data", int'(data_o[1]), 9);
      chk("clamp_u1_sign", int'(sign_o[1]), 1);

      // from -1 counting up: zero crossing and step-4 wrap
      @(negedge clk) begin load_val = 4'd1; load_neg = 1'b1; end
      @(negedge clk) begin load = 1'b0; start = 1'b1; dir = 1'b0; end
      @(negedge clk) start = 1'b0;
      wait_tick(n);
      @(posedge clk); #1;
      chk("cross_u1_data", int'(data_o[1]), 0);
      chk("cross_u1_sign", int'(sign_o[1]), 0);
      chk("step4_a_data", int'(data_o[3]), 3);
      chk("step4_a_sign", int'(sign_o[3]), 0);
      wait_tick(n);
      @(posedge clk); #1;
      chk("step4_b_data", int'(data_o[3]), 7);
      wait_tick(n);
      @(posedge clk); #1;
      chk("step4_c_data", int'(data_o[3]), 9);
      chk("step4_c_sign", int'(sign_o[3]), 1);
      chk("step4_c_lim", int'(lim_o[3]), 1);

      // random control traffic with one asynchronous reset mid-run
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         start    = ($urandom_range(0, 7) == 0);
         pause    = ($urandom_range(0, 15) == 0);
         stop     = ($urandom_range(0, 63) == 0);
         load     = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 15) == 0) dir = ~dir;
         load_val = 4'($urandom_range(0, 15));
         load_neg = 1'($urandom_range(0, 1));
         if (k == 1500) begin
            start = 1'b0; pause = 1'b0; stop = 1'b0; load = 1'b0;
            @(posedge clk);
            #3 rst_n = 1'b0;
            @(negedge clk);
            @(negedge clk) rst_n = 1'b1;
         end
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
